// File: rtl/gate_pkg.sv
// Shared op codes, expected truth tables and sequencer states for the gate self-check stage.
package gate_pkg;
   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;

   // Table bit index is {b,a}
   localparam logic [3:0] TBL_AND  = 4'b1000;
   localparam logic [3:0] TBL_OR   = 4'b1110;
   localparam logic [3:0] TBL_XOR  = 4'b0110;
   localparam logic [3:0] TBL_NOR  = 4'b0001;
   localparam logic [3:0] TBL_NAND = 4'b0111;

   typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;
endpackage

// File: rtl/gate_expect_lut.sv
// Op code -> expected 4-bit truth table; undefined codes give 0000 with valid low.
module gate_expect_lut
   import gate_pkg::*;
(
   input  logic [2:0] op,
   output logic [3:0] exp_tbl,
   output logic       exp_vld
);
   always_comb begin
      exp_tbl = 4'b0000;
      exp_vld = 1'b1;
      case (op)
         OP_AND:  exp_tbl = TBL_AND;
         OP_OR:   exp_tbl = TBL_OR;
         OP_XOR:  exp_tbl = TBL_XOR;
         OP_NOR:  exp_tbl = TBL_NOR;
         OP_NAND: exp_tbl = TBL_NAND;
         default: exp_vld = 1'b0;
      endcase
   end
endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a 2-input gate through all four operand pairs, captures its truth table
// and grades it against the table expected for the latched op code.
module gate_truth_sequencer
   import gate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] op_sel,
   input  logic       gate_out,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] table_out,
   output logic [3:0] mismatch
);
   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   state_t     state;
   logic [1:0] idx;
   logic [2:0] op_q;
   logic [3:0] cnt;
   logic [3:0] exp_tbl;
   logic       exp_vld;
   logic [3:0] final_tbl;

   gate_expect_lut u_lut (
      .op      (op_q),
      .exp_tbl (exp_tbl),
      .exp_vld (exp_vld)
   );

   // Grading must see the bit being captured this cycle, not last cycle's table
   always_comb begin
      final_tbl      = table_out;
      final_tbl[idx] = gate_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 2'd0;
         op_q      <= 3'd0;
         cnt       <= 4'd0;
         gate_a    <= 1'b0;
         gate_b    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         table_out <= 4'd0;
         mismatch  <= 4'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q             <= op_sel;
               idx              <= 2'd0;
               {gate_b, gate_a} <= 2'b00;
               table_out        <= 4'd0;
               mismatch         <= 4'd0;
               pass             <= 1'b0;
               busy             <= 1'b1;
               state            <= APPLY;
            end
            APPLY: begin
               cnt   <= SETTLE;
               state <= (SETTLE == 4'd0) ? SAMPLE : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= SAMPLE;
            end
            SAMPLE: begin
               table_out[idx] <= gate_out;
               if (idx == 2'd3) begin
                  done     <= 1'b1;
                  pass     <= exp_vld && (final_tbl == exp_tbl);
                  mismatch <= final_tbl ^ exp_tbl;
                  state    <= DONE;
               end else begin
                  idx              <= idx + 2'd1;
                  {gate_b, gate_a} <= idx + 2'd1;
                  state            <= APPLY;
               end
            end
            DONE: begin
               done             <= 1'b0;
               busy             <= 1'b0;
               {gate_b, gate_a} <= 2'b00;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed check of gate_truth_sequencer against behavioural gates with hand-computed tables.
module tb_gate_truth_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, start0;
   logic [2:0] op_sel, op0;
   logic [2:0] gmode;
   logic       gate_out, gate_a, gate_b, busy, done, pass;
   logic [3:0] table_out, mismatch;
   logic       gate_out0, gate_a0, gate_b0, busy0, done0, pass0;
   logic [3:0] table0, mismatch0;
   int         n_vec = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   // Gate under test; mode 7 is a stuck-at-0 output
   always_comb begin
      case (gmode)
         3'd0:    gate_out = gate_a & gate_b;
         3'd2:    gate_out = gate_a ^ gate_b;
         3'd3:    gate_out = ~(gate_a | gate_b);
         3'd4:    gate_out = ~(gate_a & gate_b);
         default: gate_out = 1'b0;
      endcase
   end
   assign gate_out0 = gate_a0 ^ gate_b0;

   gate_truth_sequencer #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .gate_out(gate_out),
      .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
      .table_out(table_out), .mismatch(mismatch)
   );

   gate_truth_sequencer #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .op_sel(op0), .gate_out(gate_out0),
      .gate_a(gate_a0), .gate_b(gate_b0), .busy(busy0), .done(done0), .pass(pass0),
      .table_out(table0), .mismatch(mismatch0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start in cycle 0, observe 30 cycles; optionally retry start/op_sel at cycle 5
   task automatic run(input logic [2:0] op, input bit inj, output int dc, output int nd,
                      output logic [3:0][1:0] ops, output logic b1);
      start = 1'b1; op_sel = op;
      tick();
      start = 1'b0;
      dc = -1; nd = 0; ops = '0; b1 = busy;
      for (int c = 1; c <= 30; c++) begin
         if (c == 1 || c == 5 || c == 9 || c == 13) ops[c/4] = {gate_b, gate_a};
         if (done) begin
            nd++;
            if (dc < 0) dc = c;
         end
         if (inj && c == 5) begin
            start = 1'b1; op_sel = 3'd3;
         end else if (inj && c == 6) begin
            start = 1'b0; op_sel = op;
         end
         tick();
      end
   endtask

   initial begin
      int dc, nd;
      logic [3:0][1:0] ops;
      logic b1;
      bit found;

      rst_n = 1'b0; start = 1'b0; start0 = 1'b0; op_sel = 3'd0; op0 = 3'd0; gmode = 3'd4;
      tick(); tick();
      chk("reset_outs", {gate_a, gate_b, busy, done, pass, table_out, mismatch}, 0);
      rst_n = 1'b1;
      tick();

      // 1: correct NAND
      gmode = 3'd4;
      run(3'd4, 1'b0, dc, nd, ops, b1);
      chk("nand_busy_c1", b1, 1);
      chk("nand_operands", ops, 8'b11_10_01_00);
      chk("nand_done_cyc", dc, 17);
      chk("nand_ndone", nd, 1);
      chk("nand_table", table_out, 4'b0111);
      chk("nand_mismatch", mismatch, 4'b0000);
      chk("nand_pass", pass, 1);
      chk("nand_busy_idle", busy, 0);

      // 2: stuck-at-0 gate graded as NAND
      gmode = 3'd7;
      run(3'd4, 1'b0, dc, nd, ops, b1);
      chk("stuck_done_cyc", dc, 17);
      chk("stuck_table", table_out, 4'b0000);
      chk("stuck_mismatch", mismatch, 4'b0111);
      chk("stuck_pass", pass, 0);

      // 3: zero settle, XOR
      start0 = 1'b1; op0 = 3'd2;
      tick();
      start0 = 1'b0; dc = -1; nd = 0;
      for (int c = 1; c <= 20; c++) begin
         if (done0) begin
            nd++;
            if (dc < 0) dc = c;
         end
         tick();
      end
      chk("xor0_done_cyc", dc, 9);
      chk("xor0_ndone", nd, 1);
      chk("xor0_table", table0, 4'b0110);
      chk("xor0_pass", pass0, 1);

      // 4: AND with ignored restart / op change mid-run
      gmode = 3'd0;
      run(3'd0, 1'b1, dc, nd, ops, b1);
      chk("and_done_cyc", dc, 17);
      chk("and_ndone", nd, 1);
      chk("and_table", table_out, 4'b1000);
      chk("and_pass", pass, 1);

      // 5: reset at cycle 6 of a NAND run
      gmode = 3'd4;
      start = 1'b1; op_sel = 3'd4;
      tick();
      start = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {gate_a, gate_b, busy, done, pass, table_out, mismatch}, 0);
      nd = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done) nd++;
      end
      chk("rst_mid_nodone", nd, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_idle_busy", busy, 0);
      run(3'd4, 1'b0, dc, nd, ops, b1);
      chk("rst_rerun_done", dc, 17);
      chk("rst_rerun_pass", pass, 1);

      // 6: correct NOR under undefined op 6
      gmode = 3'd3;
      run(3'd6, 1'b0, dc, nd, ops, b1);
      chk("undef_done_cyc", dc, 17);
      chk("undef_table", table_out, 4'b0001);
      chk("undef_mismatch", mismatch, 4'b0001);
      chk("undef_pass", pass, 0);

      // Back-to-back: start held through DONE is ignored there, accepted in the next IDLE cycle
      gmode = 3'd4;
      start = 1'b1; op_sel = 3'd4;
      tick();
      start = 1'b0; found = 1'b0;
      for (int c = 1; c <= 40 && !found; c++) begin
         if (done) found = 1'b1;
         else tick();
      end
      chk("b2b_first_done", found, 1);
      start = 1'b1;
      tick();
      chk("b2b_done_ignored", busy, 0);
      tick();
      start = 1'b0;
      chk("b2b_accepted", busy, 1);
      found = 1'b0;
      for (int c = 1; c <= 40 && !found; c++) begin
         if (done) found = 1'b1;
         else tick();
      end
      chk("b2b_second_done", found, 1);
      chk("b2b_second_pass", pass, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
